// File: rtl/yakirouter_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : yakirouter_out_fifo
// Brief    : Per-output-channel packet framer and FIFO with read handshake,
//            overflow flag and stale-data timeout flush.
// Revision : 1.0
// ============================================================================
module yakirouter_out_fifo #(
    parameter int DATA_SIZE = 8,
    parameter int DEPTH     = 16,
    parameter int TIMEOUT   = 30
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DATA_SIZE-1:0] i_data_in,
    input  logic                 i_vld,
    input  logic                 i_read_en,
    output logic [DATA_SIZE-1:0] o_data_out,
    output logic                 o_data_vld,
    output logic                 o_last,
    output logic                 o_empty,
    output logic                 o_full,
    output logic                 o_pkt_avail,
    output logic                 o_timeout,
    output logic                 o_overflow
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_TW = $clog2(TIMEOUT);
    localparam int c_LW = DATA_SIZE - 2;
    localparam int c_EW = DATA_SIZE + 1;

    localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(DEPTH);
    localparam logic [c_TW-1:0] c_TO_MAX   = c_TW'(TIMEOUT - 1);
    localparam logic [c_LW-1:0] c_REM_ONE  = c_LW'(1);

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PAY  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_LW-1:0]       r_rem;
    logic [c_EW-1:0]       r_mem [DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_CW-1:0]       r_count;
    logic [c_CW-1:0]       r_pkt_cnt;
    logic [c_TW-1:0]       r_to_cnt;
    logic [DATA_SIZE-1:0]  r_data_out;
    logic                  r_data_vld;
    logic                  r_last;
    logic                  r_timeout;
    logic                  r_overflow;

    logic                  w_empty;
    logic                  w_full;
    logic [c_LW-1:0]       w_hdr_len;
    logic                  w_wr_req;
    logic                  w_wr_last;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_flush;
    logic                  w_rd_last;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL_CNT);
    assign w_hdr_len = i_data_in[DATA_SIZE-1:2];

    always_comb begin
        w_wr_req  = 1'b0;
        w_wr_last = 1'b0;
        if (i_vld) begin
            case (r_state)
                S_HDR: begin
                    w_wr_req  = 1'b1;
                    w_wr_last = (w_hdr_len == '0);
                end
                S_PAY: begin
                    w_wr_req  = 1'b1;
                    w_wr_last = (r_rem == c_REM_ONE);
                end
                default: begin
                    w_wr_req  = 1'b0;
                    w_wr_last = 1'b0;
                end
            endcase
        end
    end

    // A flush can only happen while i_read_en is low, so it never collides with a read.
    assign w_flush   = !w_empty && !i_read_en && (r_to_cnt == c_TO_MAX);
    assign w_rd      = i_read_en && !w_empty;
    assign w_wr      = w_wr_req && (!w_full || w_rd) && !w_flush;
    assign w_rd_last = r_mem[r_rd_ptr][DATA_SIZE];

    // Write-side framing FSM; the length count advances even for dropped bytes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_HDR;
            r_rem   <= '0;
        end else if (i_vld) begin
            case (r_state)
                S_HDR: begin
                    r_rem <= w_hdr_len;
                    if (w_hdr_len != '0) begin
                        r_state <= w_flush ? S_DROP : S_PAY;
                    end
                end
                S_PAY, S_DROP: begin
                    r_rem <= r_rem - 1'b1;
                    if (r_rem == c_REM_ONE) begin
                        r_state <= S_HDR;
                    end else if (w_flush) begin
                        r_state <= S_DROP;
                    end
                end
                default: r_state <= S_HDR;
            endcase
        end else if (w_flush && (r_state == S_PAY)) begin
            r_state <= S_DROP;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {w_wr_last, i_data_in};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_pkt_cnt <= '0;
            r_to_cnt  <= '0;
        end else if (w_flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_pkt_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            case ({w_wr && w_wr_last, w_rd && w_rd_last})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + 1'b1;
                2'b01:   r_pkt_cnt <= r_pkt_cnt - 1'b1;
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
            if (!w_empty && !i_read_en) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data_out <= '0;
            r_data_vld <= 1'b0;
            r_last     <= 1'b0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_data_vld <= w_rd && !w_flush;
            r_timeout  <= w_flush;
            if (w_rd && !w_flush) begin
                r_data_out <= r_mem[r_rd_ptr][DATA_SIZE-1:0];
                r_last     <= w_rd_last;
            end
            if (w_wr_req && w_full && !w_rd) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_data_out  = r_data_out;
    assign o_data_vld  = r_data_vld;
    assign o_last      = r_last;
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_pkt_avail = (r_pkt_cnt != '0);
    assign o_timeout   = r_timeout;
    assign o_overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_yakirouter_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_yakirouter_out_fifo
// Brief    : Directed self-checking bench for yakirouter_out_fifo.
// Revision : 1.0
// ============================================================================
module tb_yakirouter_out_fifo;

    logic       i_clk;
    logic       i_rst;
    logic [7:0] i_data_in;
    logic       i_vld;
    logic       i_read_en;
    logic [7:0] o_data_out;
    logic       o_data_vld;
    logic       o_last;
    logic       o_empty;
    logic       o_full;
    logic       o_pkt_avail;
    logic       o_timeout;
    logic       o_overflow;

    int n_checks = 0;
    int n_errors = 0;

    yakirouter_out_fifo #(
        .DATA_SIZE(8),
        .DEPTH    (16),
        .TIMEOUT  (30)
    ) u_dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_data_in  (i_data_in),
        .i_vld      (i_vld),
        .i_read_en  (i_read_en),
        .o_data_out (o_data_out),
        .o_data_vld (o_data_vld),
        .o_last     (o_last),
        .o_empty    (o_empty),
        .o_full     (o_full),
        .o_pkt_avail(o_pkt_avail),
        .o_timeout  (o_timeout),
        .o_overflow (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        i_data_in = d;
        i_vld     = 1'b1;
        tick();
        i_vld     = 1'b0;
    endtask

    task automatic rd(input logic [7:0] exp_d, input logic exp_l, input string tag);
        i_read_en = 1'b1;
        tick();
        i_read_en = 1'b0;
        chk({tag, "_vld"}, 32'(o_data_vld), 32'd1);
        chk({tag, "_data"}, 32'(o_data_out), 32'(exp_d));
        chk({tag, "_last"}, 32'(o_last), 32'(exp_l));
    endtask

    initial begin
        logic [7:0] pkt1 [4];
        pkt1[0] = 8'h0C; pkt1[1] = 8'h11; pkt1[2] = 8'h22; pkt1[3] = 8'h33;

        i_rst = 1'b1; i_data_in = '0; i_vld = 1'b0; i_read_en = 1'b0;
        tick(); tick();
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_vld", 32'(o_data_vld), 32'd0);
        chk("rst_data", 32'(o_data_out), 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);
        chk("rst_pkt", 32'(o_pkt_avail), 32'd0);
        chk("rst_to", 32'(o_timeout), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        i_rst = 1'b0;

        // Basic 4-byte packet
        wr(pkt1[0]);
        chk("p1_nonempty", 32'(o_empty), 32'd0);
        chk("p1_pkt_early", 32'(o_pkt_avail), 32'd0);
        wr(pkt1[1]); wr(pkt1[2]);
        chk("p1_pkt_before_last", 32'(o_pkt_avail), 32'd0);
        wr(pkt1[3]);
        chk("p1_pkt_avail", 32'(o_pkt_avail), 32'd1);
        for (int i = 0; i < 4; i++) begin
            rd(pkt1[i], (i == 3), "p1_rd");
        end
        chk("p1_empty_after", 32'(o_empty), 32'd1);
        chk("p1_pkt_after", 32'(o_pkt_avail), 32'd0);
        i_read_en = 1'b1;
        tick();
        i_read_en = 1'b0;
        chk("p1_rd_empty_vld", 32'(o_data_vld), 32'd0);
        chk("p1_hold_data", 32'(o_data_out), 32'h33);

        // Header-only packet
        wr(8'h00);
        chk("p2_pkt_avail", 32'(o_pkt_avail), 32'd1);
        chk("p2_nonempty", 32'(o_empty), 32'd0);
        rd(8'h00, 1'b1, "p2_rd");
        chk("p2_pkt_after", 32'(o_pkt_avail), 32'd0);
        i_read_en = 1'b1;
        tick();
        i_read_en = 1'b0;
        chk("p2_rd_empty_vld", 32'(o_data_vld), 32'd0);

        // Overflow: 17-byte packet into 16 entries
        wr(8'h40);
        for (int i = 1; i < 16; i++) begin
            chk("p3_not_full", 32'(o_full), 32'd0);
            wr(8'(i));
        end
        chk("p3_full", 32'(o_full), 32'd1);
        chk("p3_no_ovf_yet", 32'(o_overflow), 32'd0);
        wr(8'h10);
        chk("p3_ovf", 32'(o_overflow), 32'd1);
        chk("p3_full_still", 32'(o_full), 32'd1);
        chk("p3_pkt_dropped_last", 32'(o_pkt_avail), 32'd0);
        for (int i = 0; i < 16; i++) begin
            rd((i == 0) ? 8'h40 : 8'(i), 1'b0, "p3_rd");
        end
        chk("p3_empty", 32'(o_empty), 32'd1);
        chk("p3_ovf_sticky", 32'(o_overflow), 32'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("p3_ovf_cleared", 32'(o_overflow), 32'd0);

        // Timeout on idle buffered packet: pulse 30 cycles after first write
        wr(8'h0C); wr(8'hA1); wr(8'hA2); wr(8'hA3);
        chk("p4_pkt_avail", 32'(o_pkt_avail), 32'd1);
        for (int i = 4; i < 30; i++) begin
            chk("p4_no_early_to", 32'(o_timeout), 32'd0);
            tick();
        end
        chk("p4_no_to_at_29", 32'(o_timeout), 32'd0);
        chk("p4_nonempty_at_29", 32'(o_empty), 32'd0);
        tick();
        chk("p4_to_pulse", 32'(o_timeout), 32'd1);
        chk("p4_empty", 32'(o_empty), 32'd1);
        chk("p4_pkt_cleared", 32'(o_pkt_avail), 32'd0);
        tick();
        chk("p4_to_one_cycle", 32'(o_timeout), 32'd0);

        // Timeout in the middle of a packet: rest of it must be discarded
        wr(8'h28); wr(8'hB1); wr(8'hB2); wr(8'hB3); wr(8'hB4);
        repeat (25) tick();
        chk("p5_no_to_yet", 32'(o_timeout), 32'd0);
        tick();
        chk("p5_to_pulse", 32'(o_timeout), 32'd1);
        chk("p5_empty", 32'(o_empty), 32'd1);
        for (int i = 0; i < 6; i++) begin
            wr(8'hC1 + 8'(i));
        end
        chk("p5_dropped_empty", 32'(o_empty), 32'd1);
        chk("p5_no_ovf", 32'(o_overflow), 32'd0);
        wr(8'h04);
        chk("p5_hdr_buffered", 32'(o_empty), 32'd0);
        chk("p5_pkt_partial", 32'(o_pkt_avail), 32'd0);
        wr(8'h55);
        chk("p5_pkt_avail", 32'(o_pkt_avail), 32'd1);
        rd(8'h04, 1'b0, "p5_rd_hdr");
        rd(8'h55, 1'b1, "p5_rd_pay");
        chk("p5_empty_after", 32'(o_empty), 32'd1);

        // Full FIFO with simultaneous read and write
        wr(8'h40);
        for (int i = 1; i < 16; i++) begin
            wr(8'(i));
        end
        chk("p6_full", 32'(o_full), 32'd1);
        i_data_in = 8'h10; i_vld = 1'b1; i_read_en = 1'b1;
        tick();
        chk("p6_rw_full", 32'(o_full), 32'd1);
        chk("p6_rw_no_ovf", 32'(o_overflow), 32'd0);
        chk("p6_rw_data", 32'(o_data_out), 32'h40);
        chk("p6_rw_pkt", 32'(o_pkt_avail), 32'd1);
        i_data_in = 8'h0C;
        tick();
        chk("p6_rw2_data", 32'(o_data_out), 32'h01);
        chk("p6_rw2_full", 32'(o_full), 32'd1);
        i_read_en = 1'b0;
        i_rst = 1'b1; i_data_in = 8'h11;
        tick();
        chk("p6_rst_empty", 32'(o_empty), 32'd1);
        chk("p6_rst_full", 32'(o_full), 32'd0);
        chk("p6_rst_pkt", 32'(o_pkt_avail), 32'd0);
        chk("p6_rst_vld", 32'(o_data_vld), 32'd0);
        chk("p6_rst_data", 32'(o_data_out), 32'd0);
        chk("p6_rst_last", 32'(o_last), 32'd0);
        chk("p6_rst_to", 32'(o_timeout), 32'd0);
        chk("p6_rst_ovf", 32'(o_overflow), 32'd0);
        i_rst = 1'b0; i_vld = 1'b0;
        wr(8'h00);
        chk("p6_post_rst_hdr", 32'(o_pkt_avail), 32'd1);
        rd(8'h00, 1'b1, "p6_post_rd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
